// File: rtl/cpu_pkg.sv
// Shared write-back arbitration types and defaults.
// Holds the arbiter FSM encoding and FIFO entry layout.
package cpu_pkg;

  localparam logic [0:0] ALU_PRI = 1'b0;
  localparam logic [0:0] MAC_PRI = 1'b1;

  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_STARVE_LIMIT = 3;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] wd;
  } wb_ent_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back port bundle: ALU and MAC result sources plus
// the register-file write port driven by the arbiter.
interface wb_arbiter_if;

  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        alu_stall;

  logic        mac_valid;
  logic        mac_ready;
  logic [3:0]  mac_rd;
  logic [31:0] mac_wd;

  logic        we;
  logic [3:0]  rd;
  logic [31:0] wd;
  logic [3:0]  fifo_count;
  logic        busy;

  modport slave (
    input  alu_valid, alu_rd, alu_wd,
    input  mac_valid, mac_rd, mac_wd,
    output alu_stall, mac_ready,
    output we, rd, wd, fifo_count, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_wd,
    output mac_valid, mac_rd, mac_wd,
    input  alu_stall, mac_ready,
    input  we, rd, wd, fifo_count, busy
  );

endinterface

// File: rtl/wb_fifo.sv
// Buffer for multi-cycle MAC/load results awaiting write-back.
// Caller never pushes when full nor pops when empty.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  wb_ent_t    push_data_i,
  input  logic       pop_i,
  output wb_ent_t    head_o,
  output logic [3:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_ent_t       mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [3:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= push_data_i;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wp_d  = push_i ? wp_q + AW'(1) : wp_q;
    rp_d  = pop_i  ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rp_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU results win by default,
// buffered MAC results get a slot after a run of ALU grants.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int MAC_FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT
) (
  input logic          clk,
  input logic          rst,
  wb_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [3:0]    FULL  = 4'(MAC_FIFO_DEPTH);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          we_q, we_d;
  logic [3:0]    rd_q, rd_d;
  logic [31:0]   wd_q, wd_d;

  logic       nonempty;
  logic       ready;
  logic       push;
  logic       pop;
  logic       grant_alu;
  logic       mac_turn;
  logic [3:0] count;
  wb_ent_t    head;
  wb_ent_t    push_data;

  assign push_data = {bus.mac_rd, bus.mac_wd};
  assign nonempty  = (count != 4'd0);
  assign ready     = !rst && (count < FULL);
  assign push      = bus.mac_valid && ready;
  assign mac_turn  = (state_q == MAC_PRI) && nonempty;

  wb_fifo #(
    .DEPTH (MAC_FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  always_comb begin
    state_d   = ALU_PRI;
    starve_d  = '0;
    grant_alu = 1'b0;
    pop       = 1'b0;
    unique case (1'b1)
      mac_turn: pop = 1'b1;
      !mac_turn && bus.alu_valid: begin
        grant_alu = 1'b1;
        if (nonempty) begin
          starve_d = starve_q + CW'(1);
          if (starve_d >= LIMIT) state_d = MAC_PRI;
        end
      end
      !mac_turn && !bus.alu_valid && nonempty: pop = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    we_d = grant_alu || pop;
    rd_d = rd_q;
    wd_d = wd_q;
    if (grant_alu) begin
      rd_d = bus.alu_rd;
      wd_d = bus.alu_wd;
    end else if (pop) begin
      rd_d = head.rd;
      wd_d = head.wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ALU_PRI;
      starve_q <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      wd_q     <= wd_d;
    end
  end

  assign bus.alu_stall  = rst || (bus.alu_valid && !grant_alu);
  assign bus.mac_ready  = ready;
  assign bus.we         = we_q;
  assign bus.rd         = rd_q;
  assign bus.wd         = wd_q;
  assign bus.fifo_count = count;
  assign bus.busy       = nonempty || we_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a queue-based model,
// plus directed sequences with hand-computed expectations.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic clk;
  logic rst;

  wb_arbiter_if bus ();

  wb_arbiter #(
    .MAC_FIFO_DEPTH (DEPTH),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  logic [35:0] q [$];
  int          starve;
  bit          macpri;
  logic        ew;
  logic [3:0]  erd;
  logic [31:0] ewd;
  bit          m_stall;
  bit          m_ready;
  logic        seen_stall;
  logic        seen_ready;

  task automatic chk(input string nm, input logic [35:0] act,
                     input logic [35:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    q.delete();
    starve = 0;
    macpri = 0;
    ew     = 1'b0;
    erd    = '0;
    ewd    = '0;
  endtask

  // One cycle: drive at negedge, check combinational outputs,
  // advance the model, check registered outputs after the edge.
  task automatic step(input logic av, input logic [3:0] ard,
                      input logic [31:0] awd, input logic mv,
                      input logic [3:0] mrd, input logic [31:0] mwd);
    bit ga, gf, ne;
    logic [35:0] e;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_wd    = awd;
    bus.mac_valid = mv;
    bus.mac_rd    = mrd;
    bus.mac_wd    = mwd;
    #1;
    ne = (q.size() != 0);
    m_ready = (q.size() < DEPTH);
    ga = 0;
    gf = 0;
    if (macpri && ne) begin
      gf = 1;
      starve = 0;
    end else if (av) begin
      ga = 1;
      starve = ne ? starve + 1 : 0;
    end else begin
      gf = ne;
      starve = 0;
    end
    macpri  = ga && (starve >= LIMIT);
    m_stall = av && !ga;
    seen_stall = bus.alu_stall;
    seen_ready = bus.mac_ready;
    chk("alu_stall", {35'd0, bus.alu_stall}, {35'd0, m_stall});
    chk("mac_ready", {35'd0, bus.mac_ready}, {35'd0, m_ready});
    if (ga) begin
      ew = 1'b1; erd = ard; ewd = awd;
    end else if (gf) begin
      e = q.pop_front();
      ew = 1'b1; erd = e[35:32]; ewd = e[31:0];
    end else begin
      ew = 1'b0;
    end
    if (mv && m_ready) q.push_back({mrd, mwd});
    @(posedge clk);
    #1;
    chk("we", {35'd0, bus.we}, {35'd0, ew});
    chk("rd", {32'd0, bus.rd}, {32'd0, erd});
    chk("wd", {4'd0, bus.wd}, {4'd0, ewd});
    chk("fifo_count", {32'd0, bus.fifo_count}, 36'(q.size()));
    chk("busy", {35'd0, bus.busy},
        {35'd0, (q.size() != 0) || ew});
    @(negedge clk);
  endtask

  logic        av, mv;
  logic [3:0]  ard, mrd;
  logic [31:0] awd, mwd;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_wd    = '0;
    bus.mac_valid = 1'b0;
    bus.mac_rd    = '0;
    bus.mac_wd    = '0;
    model_reset();

    @(posedge clk);
    #1;
    chk("rst_we", {35'd0, bus.we}, 36'd0);
    chk("rst_rd", {32'd0, bus.rd}, 36'd0);
    chk("rst_wd", {4'd0, bus.wd}, 36'd0);
    chk("rst_count", {32'd0, bus.fifo_count}, 36'd0);
    chk("rst_ready", {35'd0, bus.mac_ready}, 36'd0);
    chk("rst_stall", {35'd0, bus.alu_stall}, 36'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single ALU write in the first cycle after reset.
    step(1, 4'd5, 32'hDEADBEEF, 0, 0, 0);
    chk("lit_alu_we", {35'd0, bus.we}, 36'd1);
    chk("lit_alu_rd", {32'd0, bus.rd}, 36'd5);
    chk("lit_alu_wd", {4'd0, bus.wd}, 36'hDEADBEEF);
    chk("lit_alu_stall", {35'd0, seen_stall}, 36'd0);

    // Fill while ALU keeps winning.
    for (int i = 0; i < 4; i++)
      step(1, 4'd7, 32'(i), 1, 4'(i + 1), 32'(17 * (i + 1)));
    chk("lit_fill_count", {32'd0, bus.fifo_count}, 36'd4);

    // Starvation slot: FIFO head wins, fifth push refused.
    step(1, 4'd7, 32'h55, 1, 4'd5, 32'h55);
    chk("lit_full_ready", {35'd0, seen_ready}, 36'd0);
    chk("lit_starve_stall", {35'd0, seen_stall}, 36'd1);
    chk("lit_starve_rd", {32'd0, bus.rd}, 36'd1);
    chk("lit_starve_wd", {4'd0, bus.wd}, 36'h11);
    chk("lit_starve_count", {32'd0, bus.fifo_count}, 36'd3);

    step(1, 4'd7, 32'h55, 0, 0, 0);
    chk("lit_resume_rd", {32'd0, bus.rd}, 36'd7);
    chk("lit_resume_wd", {4'd0, bus.wd}, 36'h55);

    // Drain remaining entries in order.
    for (int i = 2; i <= 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("lit_drain_rd", {32'd0, bus.rd}, 36'(i));
      chk("lit_drain_wd", {4'd0, bus.wd}, 36'(17 * i));
    end
    step(0, 0, 0, 0, 0, 0);
    chk("lit_drain_busy", {35'd0, bus.busy}, 36'd0);
    chk("lit_drain_count", {32'd0, bus.fifo_count}, 36'd0);

    // Streaming push+pop across the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1, 4'(i), 32'h100 + 32'(i));
      chk("lit_stream_count", {32'd0, bus.fifo_count}, 36'd1);
      if (i > 0)
        chk("lit_stream_wd", {4'd0, bus.wd},
            36'h100 + 36'(i - 1));
    end
    step(0, 0, 0, 0, 0, 0);
    chk("lit_stream_last", {4'd0, bus.wd}, 36'h109);

    // Randomized traffic with source hold on back-pressure.
    av = 0; mv = 0; ard = 0; mrd = 0; awd = 0; mwd = 0;
    m_stall = 0; m_ready = 1;
    for (int c = 0; c < 1500; c++) begin
      if (!m_stall) begin
        av  = ($urandom_range(0, 9) < 6);
        ard = 4'($urandom);
        awd = $urandom;
      end
      if (!(mv && !m_ready)) begin
        mv  = ($urandom_range(0, 9) < 5);
        mrd = 4'($urandom);
        mwd = $urandom;
      end
      step(av, ard, awd, mv, mrd, mwd);
    end

    // Clean reset, queue three entries, then async reset mid-cycle.
    rst = 1'b1;
    bus.alu_valid = 1'b0;
    bus.mac_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++)
      step(1, 4'd9, 32'(i), 1, 4'(i + 1), 32'hA0 + 32'(i));
    chk("lit_pre_rst_count", {32'd0, bus.fifo_count}, 36'd3);
    chk("lit_pre_rst_we", {35'd0, bus.we}, 36'd1);
    bus.alu_valid = 1'b0;
    bus.mac_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("lit_async_we", {35'd0, bus.we}, 36'd0);
    chk("lit_async_count", {32'd0, bus.fifo_count}, 36'd0);
    chk("lit_async_stall", {35'd0, bus.alu_stall}, 36'd1);
    chk("lit_async_ready", {35'd0, bus.mac_ready}, 36'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("lit_rst_edge_we", {35'd0, bus.we}, 36'd0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    chk("lit_post_rst_we", {35'd0, bus.we}, 36'd0);

    // Push into empty FIFO is granted only on the next cycle.
    step(0, 0, 0, 1, 4'd3, 32'h33);
    chk("lit_push_empty_we", {35'd0, bus.we}, 36'd0);
    chk("lit_push_empty_cnt", {32'd0, bus.fifo_count}, 36'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("lit_next_grant_rd", {32'd0, bus.rd}, 36'd3);
    chk("lit_next_grant_wd", {4'd0, bus.wd}, 36'h33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
